// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with an iterative 32-cycle shift-add multiplier and restoring divider.
// A sign-fix cycle follows the iterations; busy stalls decode while an operation is in flight.
module hilo_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] op_x,
  input  logic [XLEN-1:0] op_y,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] cond_abs(input logic signed [XLEN-1:0] v, input logic en);
    return (en && v < 0) ? neg_x(v) : v;
  endfunction

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_acc;   // product high half / partial remainder
  logic [XLEN-1:0]   r_mq;    // multiplier / dividend-then-quotient
  logic [XLEN-1:0]   r_opnd;  // multiplicand / divisor
  logic              r_is_div;
  logic              r_sign_q;
  logic              r_sign_r;
  logic              r_dbz_pend;
  logic              r_done;
  logic              r_dbz;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic              w_accept;
  logic              w_signed_op;
  logic [XLEN-1:0]   w_abs_x;
  logic [XLEN-1:0]   w_abs_y;
  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_dshift;
  logic [XLEN-1:0]   w_ddiff;
  logic              w_dge;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

  assign w_accept    = op_valid && !busy && !flush;
  assign w_signed_op = !op_code[2] && !op_code[0];
  assign w_abs_x     = cond_abs(op_x, w_signed_op);
  assign w_abs_y     = cond_abs(op_y, w_signed_op);

  assign w_madd   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opnd} : '0);
  assign w_dshift = {r_acc, r_mq[XLEN-1]};
  assign w_dge    = (w_dshift >= {1'b0, r_opnd});
  assign w_ddiff  = w_dshift[XLEN-1:0] - r_opnd;

  // With a zero divisor the remainder path returns |x| re-signed by x's sign, i.e. x itself.
  assign w_prod_fix = r_sign_q ? neg_2x({r_acc, r_mq}) : {r_acc, r_mq};
  assign w_quo_fix  = r_dbz_pend ? '1 : (r_sign_q ? neg_x(r_mq) : r_mq);
  assign w_rem_fix  = r_sign_r ? neg_x(r_acc) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mq       <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op_code)
              OP_MTHI: r_hi <= op_x;
              OP_MTLO: r_lo <= op_x;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_state    <= S_RUN;
                r_cnt      <= '0;
                r_acc      <= '0;
                r_is_div   <= op_code[1];
                r_mq       <= op_code[1] ? w_abs_x : w_abs_y;
                r_opnd     <= op_code[1] ? w_abs_y : w_abs_x;
                r_sign_q   <= w_signed_op && (op_x[XLEN-1] ^ op_y[XLEN-1]);
                r_sign_r   <= w_signed_op && op_x[XLEN-1];
                r_dbz_pend <= op_code[1] && (op_y == '0);
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            if (r_is_div) begin
              r_acc <= w_dge ? w_ddiff : w_dshift[XLEN-1:0];
              r_mq  <= {r_mq[XLEN-2:0], w_dge};
            end else begin
              r_acc <= w_madd[XLEN:1];
              r_mq  <= {w_madd[0], r_mq[XLEN-1:1]};
            end
            if (r_cnt == LAST_ITER) begin
              r_state <= S_FIX;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!flush) begin
            r_hi   <= r_is_div ? w_rem_fix : w_prod_fix[2*XLEN-1:XLEN];
            r_lo   <= r_is_div ? w_quo_fix : w_prod_fix[XLEN-1:0];
            r_done <= 1'b1;
            r_dbz  <= r_dbz_pend;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: products, quotients, divide-by-zero, MTHI/MTLO, flush and async reset.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_x;
  logic [31:0] op_y;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  hilo_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_x        (op_x),
    .op_y        (op_y),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a request before an edge, lets it be accepted, and returns at the following negedge.
  task automatic issue(input logic [2:0] code, input logic [31:0] x, input logic [31:0] y);
    op_code  = code;
    op_x     = x;
    op_y     = y;
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Called at the negedge after the accept edge; cyc is 34 when done shows after edge E33.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int done_seen;

  initial begin
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_code  = 3'd0;
    op_x     = '0;
    op_y     = '0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU all-ones squared
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_after_accept", busy, 1);
    wait_done(cyc);
    chk("multu_latency", cyc, 34);
    chk("multu_busy_on_done", busy, 0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    chk("multu_dbz", div_by_zero, 0);
    @(negedge clk);
    chk("multu_done_one_cycle", done, 0);

    // MULT -3 * 5
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done(cyc);
    chk("mult_latency", cyc, 34);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    chk("div_latency", cyc, 34);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 100 / 0
    issue(3'd3, 32'd100, 32'd0);
    wait_done(cyc);
    chk("divz_latency", cyc, 34);
    chk("divz_hi", hi, 32'h0000_0064);
    chk("divz_lo", lo, 32'hFFFF_FFFF);
    chk("divz_flag", div_by_zero, 1);
    @(negedge clk);
    chk("divz_flag_clears", div_by_zero, 0);

    // DIV signed overflow wraps
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("ovf_latency", cyc, 34);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("ovf_dbz", div_by_zero, 0);

    // DIV signed by zero: hi returns the original negative dividend
    issue(3'd2, 32'hFFFF_FFF9, 32'd0);
    wait_done(cyc);
    chk("sdivz_hi", hi, 32'hFFFF_FFF9);
    chk("sdivz_lo", lo, 32'hFFFF_FFFF);
    chk("sdivz_flag", div_by_zero, 1);

    // MTHI then MTLO on consecutive cycles
    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_busy", busy, 0);
    chk("mthi_hi", hi, 32'h1234_5678);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);

    // Reserved opcode and flush-with-request are dropped
    issue(3'd6, 32'd1, 32'd1);
    chk("reserved_idle", busy, 0);
    flush = 1'b1;
    issue(3'd1, 32'd1, 32'd1);
    flush = 1'b0;
    chk("flush_idle_drop", busy, 0);

    // DIVU 50/7 flushed on iteration 10
    issue(3'd3, 32'd50, 32'd7);
    repeat (9) @(negedge clk);
    chk("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_drop", busy, 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    chk("flush_no_done", done_seen, 0);
    chk("flush_hi_kept", hi, 32'h1234_5678);
    chk("flush_lo_kept", lo, 32'h9ABC_DEF0);

    // Back-to-back: MULTU held while DIVU 9/4 runs
    issue(3'd3, 32'd9, 32'd4);
    op_code  = 3'd1;
    op_x     = 32'd6;
    op_y     = 32'd7;
    op_valid = 1'b1;
    wait_done(cyc);
    chk("b2b_first_latency", cyc, 34);
    chk("b2b_first_lo", lo, 32'd2);
    chk("b2b_first_hi", hi, 32'd1);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    chk("b2b_second_busy", busy, 1);
    wait_done(cyc);
    chk("b2b_second_latency", cyc, 34);
    chk("b2b_second_lo", lo, 32'd42);
    chk("b2b_second_hi", hi, 32'd0);

    // Asynchronous reset mid-RUN
    issue(3'd0, 32'd3, 32'd3);
    repeat (5) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_lo", lo, 32'd42);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_hi", hi, 0);
    chk("rst_async_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd1, 32'd2, 32'd3);
    wait_done(cyc);
    chk("post_rst_latency", cyc, 34);
    chk("post_rst_lo", lo, 32'd6);
    chk("post_rst_hi", hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
